// File: rtl/gf_mul_array.sv
// Nine-lane GF(2^E) multiplier. Each lane is a digit-serial MSB-first multiplier.
// All lanes share one IDLE/RUN controller with a start/busy/done handshake.
module gf_mul_array #(
  parameter int          E    = 13,
  parameter logic [16:0] POLY = 17'h0201B,
  parameter int          D    = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mul_start,
  input  logic [0:15] mul1_o_in,
  input  logic [0:15] mul2_o_in,
  input  logic [0:15] mul3_o_in,
  input  logic [0:15] mul4_o_in,
  input  logic [0:15] mul5_o_in,
  input  logic [0:15] mul6_o_in,
  input  logic [0:15] mul7_o_in,
  input  logic [0:15] mul8_o_in,
  input  logic [0:15] mul9_o_in,
  input  logic [0:15] mul1_t_in,
  input  logic [0:15] mul2_t_in,
  input  logic [0:15] mul3_t_in,
  input  logic [0:15] mul4_t_in,
  input  logic [0:15] mul5_t_in,
  input  logic [0:15] mul6_t_in,
  input  logic [0:15] mul7_t_in,
  input  logic [0:15] mul8_t_in,
  input  logic [0:15] mul9_t_in,
  output logic [0:15] mul1_r_dat,
  output logic [0:15] mul2_r_dat,
  output logic [0:15] mul3_r_dat,
  output logic [0:15] mul4_r_dat,
  output logic [0:15] mul5_r_dat,
  output logic [0:15] mul6_r_dat,
  output logic [0:15] mul7_r_dat,
  output logic [0:15] mul8_r_dat,
  output logic [0:15] mul9_r_dat,
  output logic        mul_busy,
  output logic        mul_done
);
  localparam int NDIG = (E + D - 1) / D;
  localparam int TW   = NDIG * D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [15:0] HI_MASK = ~((16'd1 << E) - 16'd1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          accept;
  logic          last;
  logic          unused_hi;
  logic [15:0]   o_in  [9];
  logic [15:0]   t_in  [9];
  logic [E-1:0]  o_q   [9];
  logic [E-1:0]  t_q   [9];
  logic [E-1:0]  acc_q [9];
  logic [E-1:0]  acc_d [9];
  logic [E-1:0]  r_q   [9];
  int            shift;

  // Port bit 15 is x^0, so a plain vector copy keeps numeric weight.
  assign o_in = '{mul1_o_in, mul2_o_in, mul3_o_in, mul4_o_in, mul5_o_in,
                  mul6_o_in, mul7_o_in, mul8_o_in, mul9_o_in};
  assign t_in = '{mul1_t_in, mul2_t_in, mul3_t_in, mul4_t_in, mul5_t_in,
                  mul6_t_in, mul7_t_in, mul8_t_in, mul9_t_in};

  function automatic logic [E-1:0] mul_x(input logic [E-1:0] a);
    logic [E:0] s;
    s = {a, 1'b0};
    if (s[E]) s = s ^ POLY[E:0];
    return s[E-1:0];
  endfunction

  // Horner over the digit bits: acc*x^D + o*digit, reduced at every step.
  function automatic logic [E-1:0] mac_digit(input logic [E-1:0] acc,
                                             input logic [E-1:0] o,
                                             input logic [D-1:0] dig);
    logic [E-1:0] a;
    a = acc;
    for (int j = D - 1; j >= 0; j--) a = mul_x(a) ^ (dig[j] ? o : '0);
    return a;
  endfunction

  assign accept = (state_q == IDLE) && mul_start;
  assign last   = (state_q == RUN) && (cnt_q == CW'(NDIG - 1));

  always_comb begin
    shift = (NDIG - 1 - int'(cnt_q)) * D;
    for (int k = 0; k < 9; k++)
      acc_d[k] = mac_digit(acc_q[k], o_q[k], D'(TW'(t_q[k]) >> shift));
  end

  always_comb begin
    unused_hi = 1'b0;
    for (int k = 0; k < 9; k++)
      unused_hi = unused_hi ^ (^(o_in[k] & HI_MASK)) ^ (^(t_in[k] & HI_MASK));
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      if (accept)               cnt_q <= '0;
      else if (state_q == RUN)  cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_busy = (state_q == RUN);
    mul_done = done_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 9; k++) begin
        o_q[k]   <= '0;
        t_q[k]   <= '0;
        acc_q[k] <= '0;
        r_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (accept) begin
          o_q[k]   <= o_in[k][E-1:0];
          t_q[k]   <= t_in[k][E-1:0];
          acc_q[k] <= '0;
        end else if (state_q == RUN) begin
          acc_q[k] <= acc_d[k];
          if (last) r_q[k] <= acc_d[k];
        end
      end
    end
  end

  assign mul1_r_dat = 16'(r_q[0]);
  assign mul2_r_dat = 16'(r_q[1]);
  assign mul3_r_dat = 16'(r_q[2]);
  assign mul4_r_dat = 16'(r_q[3]);
  assign mul5_r_dat = 16'(r_q[4]);
  assign mul6_r_dat = 16'(r_q[5]);
  assign mul7_r_dat = 16'(r_q[6]);
  assign mul8_r_dat = 16'(r_q[7]);
  assign mul9_r_dat = 16'(r_q[8]);

endmodule

// File: tb/tb_gf_mul_array.sv
// Bench for gf_mul_array: scoreboarded nine-lane products against a schoolbook
// GF(2^13) model, handshake timing, async reset abort and digit-size variants.
module tb_gf_mul_array;
  localparam int          E    = 13;
  localparam logic [16:0] POLY = 17'h0201B;
  localparam logic [15:0] LOW  = 16'h1FFF;

  logic        clk, rst_b, mul_start, start_sw;
  logic [15:0] o [9];
  logic [15:0] t [9];
  logic [15:0] r [9];
  logic [15:0] r1 [9];
  logic [15:0] r13 [9];
  logic        mul_busy, mul_done, busy1, done1, busy13, done13;

  int vectors = 0;
  int miscompares = 0;
  int done_total = 0;
  logic [143:0] exp_q [$];

  gf_mul_array u_dut (
    .clk(clk), .rst_b(rst_b), .mul_start(mul_start),
    .mul1_o_in(o[0]), .mul2_o_in(o[1]), .mul3_o_in(o[2]), .mul4_o_in(o[3]), .mul5_o_in(o[4]),
    .mul6_o_in(o[5]), .mul7_o_in(o[6]), .mul8_o_in(o[7]), .mul9_o_in(o[8]),
    .mul1_t_in(t[0]), .mul2_t_in(t[1]), .mul3_t_in(t[2]), .mul4_t_in(t[3]), .mul5_t_in(t[4]),
    .mul6_t_in(t[5]), .mul7_t_in(t[6]), .mul8_t_in(t[7]), .mul9_t_in(t[8]),
    .mul1_r_dat(r[0]), .mul2_r_dat(r[1]), .mul3_r_dat(r[2]), .mul4_r_dat(r[3]), .mul5_r_dat(r[4]),
    .mul6_r_dat(r[5]), .mul7_r_dat(r[6]), .mul8_r_dat(r[7]), .mul9_r_dat(r[8]),
    .mul_busy(mul_busy), .mul_done(mul_done));

  gf_mul_array #(.E(E), .POLY(POLY), .D(1)) u_d1 (
    .clk(clk), .rst_b(rst_b), .mul_start(start_sw),
    .mul1_o_in(o[0]), .mul2_o_in(o[1]), .mul3_o_in(o[2]), .mul4_o_in(o[3]), .mul5_o_in(o[4]),
    .mul6_o_in(o[5]), .mul7_o_in(o[6]), .mul8_o_in(o[7]), .mul9_o_in(o[8]),
    .mul1_t_in(t[0]), .mul2_t_in(t[1]), .mul3_t_in(t[2]), .mul4_t_in(t[3]), .mul5_t_in(t[4]),
    .mul6_t_in(t[5]), .mul7_t_in(t[6]), .mul8_t_in(t[7]), .mul9_t_in(t[8]),
    .mul1_r_dat(r1[0]), .mul2_r_dat(r1[1]), .mul3_r_dat(r1[2]), .mul4_r_dat(r1[3]), .mul5_r_dat(r1[4]),
    .mul6_r_dat(r1[5]), .mul7_r_dat(r1[6]), .mul8_r_dat(r1[7]), .mul9_r_dat(r1[8]),
    .mul_busy(busy1), .mul_done(done1));

  gf_mul_array #(.E(E), .POLY(POLY), .D(13)) u_d13 (
    .clk(clk), .rst_b(rst_b), .mul_start(start_sw),
    .mul1_o_in(o[0]), .mul2_o_in(o[1]), .mul3_o_in(o[2]), .mul4_o_in(o[3]), .mul5_o_in(o[4]),
    .mul6_o_in(o[5]), .mul7_o_in(o[6]), .mul8_o_in(o[7]), .mul9_o_in(o[8]),
    .mul1_t_in(t[0]), .mul2_t_in(t[1]), .mul3_t_in(t[2]), .mul4_t_in(t[3]), .mul5_t_in(t[4]),
    .mul6_t_in(t[5]), .mul7_t_in(t[6]), .mul8_t_in(t[7]), .mul9_t_in(t[8]),
    .mul1_r_dat(r13[0]), .mul2_r_dat(r13[1]), .mul3_r_dat(r13[2]), .mul4_r_dat(r13[3]), .mul5_r_dat(r13[4]),
    .mul6_r_dat(r13[5]), .mul7_r_dat(r13[6]), .mul8_r_dat(r13[7]), .mul9_r_dat(r13[8]),
    .mul_busy(busy13), .mul_done(done13));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schoolbook product followed by long-division reduction.
  function automatic logic [15:0] gmul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] am, bm;
    am = a & LOW;
    bm = b & LOW;
    p  = '0;
    for (int i = 0; i < E; i++) if (bm[i]) p = p ^ (32'(am) << i);
    for (int k = 2 * E - 2; k >= E; k--) if (p[k]) p = p ^ (32'(POLY) << (k - E));
    return p[15:0];
  endfunction

  function automatic logic [143:0] model_all();
    logic [143:0] e;
    for (int k = 0; k < 9; k++) e[k*16 +: 16] = gmul(o[k], t[k]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < 9; k++) begin
      o[k] = 16'($urandom);
      t[k] = 16'($urandom);
    end
  endtask

  // Latency is the index of the edge after which mul_done is seen; start edge is 0.
  task automatic do_req(output int lat);
    exp_q.push_back(model_all());
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    lat = 0;
    while (mul_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  always @(posedge clk) begin
    logic [143:0] e;
    #1;
    if (mul_done === 1'b1) begin
      done_total++;
      vectors++;
      assert (exp_q.size() > 0) else begin
        miscompares++;
        $error("FAIL done_without_request: observed queue %0d, expected nonzero", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 9; k++) chk($sformatf("sb_lane%0d", k + 1), r[k], e[k*16 +: 16]);
      end
    end
  end

  initial begin
    int lat, snap;
    int pos [$];
    logic [15:0] keep;
    logic [143:0] e;

    rst_b = 1'b0;
    mul_start = 1'b0;
    start_sw = 1'b0;
    for (int k = 0; k < 9; k++) begin o[k] = '0; t[k] = '0; end
    tick(); tick();
    chk("rst_busy", 16'(mul_busy), 16'd0);
    chk("rst_done", 16'(mul_done), 16'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("rst_r%0d", k + 1), r[k], 16'h0000);
    #2 rst_b = 1'b1;
    tick();

    // x^12 * x reduces to x^4+x^3+x+1
    o[0] = 16'h1000; t[0] = 16'h0002;
    exp_q.push_back(model_all());
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    chk("first_busy", 16'(mul_busy), 16'd1);
    chk("first_done_low", 16'(mul_done), 16'd0);
    lat = 0;
    while (mul_done !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("first_latency", 16'(lat), 16'd4);
    chk("first_busy_at_done", 16'(mul_busy), 16'd0);
    chk("first_r1", r[0], 16'h001B);
    tick();
    chk("done_one_cycle", 16'(mul_done), 16'd0);

    o[0] = 16'h0001; t[0] = 16'h1ABC;
    o[1] = 16'h1000; t[1] = 16'h1000;
    o[2] = 16'h0000; t[2] = 16'h1FFF;
    for (int k = 3; k < 9; k++) begin o[k] = t[k % 3]; t[k] = o[k % 3]; end
    do_req(lat);
    chk("lanes_latency", 16'(lat), 16'd4);
    for (int k = 0; k < 9; k++)
      chk($sformatf("lanes_r%0d", k + 1), r[k], (k % 3 == 0) ? 16'h1ABC : (k % 3 == 1) ? 16'h185A : 16'h0000);

    o[0] = 16'hE001; t[0] = 16'hA005;
    do_req(lat);
    chk("pad_r1", r[0], 16'h0005);
    chk("pad_top_bits", r[0] & 16'hE000, 16'h0000);
    tick();

    // Continuous start: one acceptance per five cycles.
    randomize_ops();
    for (int j = 0; j < 3; j++) exp_q.push_back(model_all());
    mul_start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mul_done === 1'b1) pos.push_back(i);
    end
    mul_start = 1'b0;
    chk("cont_done_count", 16'(pos.size()), 16'd3);
    for (int j = 0; j < 3; j++)
      chk($sformatf("cont_done_pos%0d", j), 16'((j < pos.size()) ? pos[j] : -1), 16'(4 + 5 * j));
    tick();
    chk("cont_idle_after", 16'(mul_busy), 16'd0);

    // Operands changed and start re-pulsed while busy.
    randomize_ops();
    e = model_all();
    snap = done_total;
    exp_q.push_back(e);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    randomize_ops();
    tick();
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    lat = 2;
    while (mul_done !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("busy_start_latency", 16'(lat), 16'd4);
    keep = r[4];
    for (int i = 0; i < 6; i++) tick();
    chk("busy_start_one_done", 16'(done_total - snap), 16'd1);
    chk("busy_start_r5_held", r[4], e[4*16 +: 16]);
    chk("busy_start_r5_stable", r[4], keep);

    // Async reset during the second RUN cycle aborts the request.
    randomize_ops();
    o[0] = 16'h0003; t[0] = 16'h0005;
    exp_q.push_back(model_all());
    snap = done_total;
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    tick();
    #2 rst_b = 1'b0;
    #1;
    chk("abort_busy", 16'(mul_busy), 16'd0);
    chk("abort_done", 16'(mul_done), 16'd0);
    chk("abort_r1", r[0], 16'h0000);
    chk("abort_r9", r[8], 16'h0000);
    void'(exp_q.pop_back());
    tick(); tick();
    #2 rst_b = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_done", 16'(done_total - snap), 16'd0);
    randomize_ops();
    o[0] = 16'h0003; t[0] = 16'h0005;
    do_req(lat);
    chk("after_abort_latency", 16'(lat), 16'd4);
    chk("after_abort_r1", r[0], 16'h000F);

    // Back-to-back random requests against the scoreboard.
    for (int n = 0; n < 1200; n++) begin
      randomize_ops();
      do_req(lat);
      chk("rand_latency", 16'(lat), 16'd4);
    end
    tick(); tick();
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    // Digit-size variants: D=13 finishes after edge 1, D=1 after edge 13.
    for (int n = 0; n < 20; n++) begin
      randomize_ops();
      e = model_all();
      start_sw = 1'b1;
      tick();
      start_sw = 1'b0;
      chk("d13_busy", 16'(busy13), 16'd1);
      tick();
      chk("d13_done", 16'(done13), 16'd1);
      chk("d1_busy", 16'(busy1), 16'd1);
      for (int k = 0; k < 9; k++) chk($sformatf("d13_r%0d", k + 1), r13[k], e[k*16 +: 16]);
      lat = 1;
      while (done1 !== 1'b1 && lat < 40) begin tick(); lat++; end
      chk("d1_latency", 16'(lat), 16'd13);
      for (int k = 0; k < 9; k++) chk($sformatf("d1_r%0d", k + 1), r1[k], e[k*16 +: 16]);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
